// File: rtl/axi4_lite_slv_template_if.sv
// AXI4-Lite bus bundle shared by masters and slaves.
// Widths are parameters so every endpoint agrees on one definition.
interface axi4_lite_if #(
    parameter int AXI4_LITE_ADDR_BIT_WIDTH = 4,
    parameter int AXI4_LITE_DATA_BIT_WIDTH = 32
);
    localparam int SW = AXI4_LITE_DATA_BIT_WIDTH / 8;

    logic [AXI4_LITE_ADDR_BIT_WIDTH-1:0] awaddr;
    logic [2:0]                          awprot;
    logic                                awvalid;
    logic                                awready;
    logic [AXI4_LITE_DATA_BIT_WIDTH-1:0] wdata;
    logic [SW-1:0]                       wstrb;
    logic                                wvalid;
    logic                                wready;
    logic [1:0]                          bresp;
    logic                                bvalid;
    logic                                bready;
    logic [AXI4_LITE_ADDR_BIT_WIDTH-1:0] araddr;
    logic [2:0]                          arprot;
    logic                                arvalid;
    logic                                arready;
    logic [AXI4_LITE_DATA_BIT_WIDTH-1:0] rdata;
    logic [1:0]                          rresp;
    logic                                rvalid;
    logic                                rready;

    modport slv_port (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid,
        output arready, rdata, rresp, rvalid
    );

    modport mst_port (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid,
        input  arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4_lite_slv_template.sv
// Template AXI4-Lite slave: four 32-bit R/W registers.
// Write and read paths are independent; every access returns OKAY.
module axi4_lite_slv_template #(
    parameter int AXI4_LITE_ADDR_BIT_WIDTH = 4,
    parameter int AXI4_LITE_DATA_BIT_WIDTH = 32
) (
    input logic            i_clk,
    input logic            i_sync_rst,
    axi4_lite_if.slv_port  if_s_axi4_lite
);
    localparam int DW    = AXI4_LITE_DATA_BIT_WIDTH;
    localparam int SW    = DW / 8;
    localparam int LSB   = 2;
    localparam int IDX_W = 2;
    localparam logic [1:0] OKAY = 2'b00;

    logic [DW-1:0]    regs [4];
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             wr_hs;
    logic             rd_hs;
    logic             unused_ok;

    assign wr_idx = if_s_axi4_lite.awaddr[LSB +: IDX_W];
    assign rd_idx = if_s_axi4_lite.araddr[LSB +: IDX_W];

    assign wr_hs = if_s_axi4_lite.awvalid && if_s_axi4_lite.awready
                && if_s_axi4_lite.wvalid  && if_s_axi4_lite.wready;
    assign rd_hs = if_s_axi4_lite.arvalid && if_s_axi4_lite.arready;

    assign unused_ok = ^{if_s_axi4_lite.awprot, if_s_axi4_lite.arprot,
                         if_s_axi4_lite.awaddr[LSB-1:0],
                         if_s_axi4_lite.araddr[LSB-1:0]};

    // AW and W are only taken together, and never while a B is pending.
    always_ff @(posedge i_clk or posedge i_sync_rst) begin
        if (i_sync_rst) begin
            if_s_axi4_lite.awready <= 1'b0;
            if_s_axi4_lite.wready  <= 1'b0;
            if_s_axi4_lite.bvalid  <= 1'b0;
            if_s_axi4_lite.bresp   <= OKAY;
        end else begin
            if_s_axi4_lite.awready <= if_s_axi4_lite.awvalid
                                   && if_s_axi4_lite.wvalid
                                   && !if_s_axi4_lite.bvalid
                                   && !if_s_axi4_lite.awready;
            if_s_axi4_lite.wready  <= if_s_axi4_lite.awvalid
                                   && if_s_axi4_lite.wvalid
                                   && !if_s_axi4_lite.bvalid
                                   && !if_s_axi4_lite.awready;
            if (wr_hs) begin
                if_s_axi4_lite.bvalid <= 1'b1;
                if_s_axi4_lite.bresp  <= OKAY;
            end else if (if_s_axi4_lite.bvalid && if_s_axi4_lite.bready) begin
                if_s_axi4_lite.bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_sync_rst) begin
        if (i_sync_rst) begin
            for (int r = 0; r < 4; r++) begin
                regs[r] <= '0;
            end
        end else if (wr_hs) begin
            for (int i = 0; i < SW; i++) begin
                if (if_s_axi4_lite.wstrb[i]) begin
                    regs[wr_idx][8*i +: 8] <= if_s_axi4_lite.wdata[8*i +: 8];
                end
            end
        end
    end

    // rdata samples the register before any same-edge write lands.
    always_ff @(posedge i_clk or posedge i_sync_rst) begin
        if (i_sync_rst) begin
            if_s_axi4_lite.arready <= 1'b0;
            if_s_axi4_lite.rvalid  <= 1'b0;
            if_s_axi4_lite.rresp   <= OKAY;
            if_s_axi4_lite.rdata   <= '0;
        end else begin
            if_s_axi4_lite.arready <= if_s_axi4_lite.arvalid
                                   && !if_s_axi4_lite.arready
                                   && !if_s_axi4_lite.rvalid;
            if (rd_hs) begin
                if_s_axi4_lite.rdata  <= regs[rd_idx];
                if_s_axi4_lite.rresp  <= OKAY;
                if_s_axi4_lite.rvalid <= 1'b1;
            end else if (if_s_axi4_lite.rvalid && if_s_axi4_lite.rready) begin
                if_s_axi4_lite.rvalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axi4_lite_slv_template.sv
// Bench for axi4_lite_slv_template: directed cases plus random traffic,
// responses checked by a queue-based scoreboard against a register model.
module tb_axi4_lite_slv_template;
    logic i_clk = 1'b0;
    logic i_sync_rst = 1'b1;

    always #4 i_clk = ~i_clk;

    axi4_lite_if #(
        .AXI4_LITE_ADDR_BIT_WIDTH(4),
        .AXI4_LITE_DATA_BIT_WIDTH(32)
    ) bus ();

    axi4_lite_slv_template #(
        .AXI4_LITE_ADDR_BIT_WIDTH(4),
        .AXI4_LITE_DATA_BIT_WIDTH(32)
    ) dut (
        .i_clk(i_clk),
        .i_sync_rst(i_sync_rst),
        .if_s_axi4_lite(bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] model [4];
    logic [1:0]  exp_b [$];
    logic [31:0] exp_r [$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: one pop per completed B or R handshake.
    always @(negedge i_clk) begin
        if (!i_sync_rst) begin
            if (bus.bvalid && bus.bready) begin
                checks++;
                if (exp_b.size() == 0) begin
                    errors++;
                    $display("FAIL b_unexpected: got bvalid expected none");
                end else begin
                    logic [1:0] eb;
                    eb = exp_b.pop_front();
                    if (bus.bresp !== eb) begin
                        errors++;
                        $display("FAIL bresp: got %b expected %b", bus.bresp, eb);
                    end
                end
            end
            if (bus.rvalid && bus.rready) begin
                checks++;
                if (exp_r.size() == 0) begin
                    errors++;
                    $display("FAIL r_unexpected: got rvalid expected none");
                end else begin
                    logic [31:0] er;
                    er = exp_r.pop_front();
                    if (bus.rdata !== er || bus.rresp !== 2'b00) begin
                        errors++;
                        $display("FAIL rdata: got %h/%b expected %h/00",
                                 bus.rdata, bus.rresp, er);
                    end
                end
            end
        end
    end

    task automatic do_write(input logic [3:0] addr, input logic [31:0] data,
                            input logic [3:0] strb);
        int n;
        logic [31:0] mask;
        @(posedge i_clk);
        #1;
        bus.awaddr  = addr;
        bus.awprot  = 3'($urandom);
        bus.awvalid = 1'b1;
        bus.wdata   = data;
        bus.wstrb   = strb;
        bus.wvalid  = 1'b1;
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (!bus.awready && n < 50);
        chk("aw_accept", {31'd0, bus.awready}, 32'd1);
        chk("w_with_aw", {31'd0, bus.wready}, 32'd1);
        @(posedge i_clk);
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        model[addr[3:2]] = (model[addr[3:2]] & ~mask) | (data & mask);
        exp_b.push_back(2'b00);
        #1;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        @(negedge i_clk);
        chk("aw_pulse", {31'd0, bus.awready}, 32'd0);
        chk("b_latency", {31'd0, bus.bvalid}, 32'd1);
    endtask

    task automatic do_read(input logic [3:0] addr);
        int n;
        @(posedge i_clk);
        #1;
        bus.araddr  = addr;
        bus.arprot  = 3'($urandom);
        bus.arvalid = 1'b1;
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (!bus.arready && n < 50);
        chk("ar_accept", {31'd0, bus.arready}, 32'd1);
        @(posedge i_clk);
        exp_r.push_back(model[addr[3:2]]);
        #1;
        bus.arvalid = 1'b0;
        @(negedge i_clk);
        chk("ar_pulse", {31'd0, bus.arready}, 32'd0);
        chk("r_latency", {31'd0, bus.rvalid}, 32'd1);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_outs"},
            {24'd0, bus.awready, bus.wready, bus.bvalid, bus.arready,
             bus.rvalid, bus.bresp == 2'b00, bus.rresp == 2'b00, 1'b0},
            32'h0000_0006);
        chk({tag, "_rdata"}, bus.rdata, 32'h0);
    endtask

    initial begin
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b1;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b1;
        for (int i = 0; i < 4; i++) model[i] = '0;

        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check_idle("reset");
        @(posedge i_clk);
        #1;
        i_sync_rst = 1'b0;
        for (int i = 0; i < 4; i++) do_read(4'(i * 4));

        do_write(4'h0, 32'h1234_5678, 4'hF);
        do_read(4'h0);
        do_write(4'h1, 32'h8765_4321, 4'hF);
        do_read(4'h0);
        do_read(4'h4);
        do_write(4'h8, 32'hFFFF_FFFF, 4'hF);
        do_write(4'h8, 32'h0000_0000, 4'h5);
        do_read(4'h8);

        // B backpressure: a second write must stall until bready.
        bus.bready = 1'b0;
        do_write(4'hC, 32'hA5A5_0001, 4'hF);
        fork
            do_write(4'hC, 32'h5A5A_0002, 4'h3);
            begin
                repeat (5) begin
                    @(negedge i_clk);
                    chk("bp_bvalid", {31'd0, bus.bvalid}, 32'd1);
                    chk("bp_awready", {31'd0, bus.awready}, 32'd0);
                end
                @(posedge i_clk);
                #1;
                bus.bready = 1'b1;
            end
        join
        do_read(4'hC);

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 1) == 1)
                do_write(4'($urandom_range(0, 15)), $urandom,
                         4'($urandom_range(0, 15)));
            else
                do_read(4'($urandom_range(0, 15)));
        end

        // Reset while an R response is pending.
        bus.rready = 1'b0;
        do_read(4'h8);
        #1;
        i_sync_rst = 1'b1;
        #1;
        chk("rst_rvalid_drop", {31'd0, bus.rvalid}, 32'd0);
        exp_r.delete();
        exp_b.delete();
        for (int i = 0; i < 4; i++) model[i] = '0;
        @(negedge i_clk);
        check_idle("midrst");
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        i_sync_rst = 1'b0;
        bus.rready = 1'b1;
        for (int i = 0; i < 4; i++) do_read(4'(i * 4));

        for (int n = 0; n < 20 && (exp_b.size() + exp_r.size()) != 0; n++)
            @(negedge i_clk);
        chk("drain", 32'(exp_b.size() + exp_r.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
